uart_rx_ext: RTL and testbench



---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_majority_sampler.sv | 43 ++++
 rtl/uart_rx_ext.sv | 206 ++++++++++++++++++++
 tb/tb_uart_rx_ext.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, parity modes and
// the oversample positions used for 3-sample majority voting.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // idx 0..2 selects the samples at OVS/2-1, OVS/2 and OVS/2+1
  function automatic int vote_pos(input int ovs, input int idx);
    return ovs / 2 - 1 + idx;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_majority_sampler.sv
// Two-flop synchroniser for the serial line plus the 3-sample mid-bit majority vote.
module uart_majority_sampler
  import uart_pkg::*;
#(
  parameter int OVS = 16,
  parameter int SW  = $clog2(OVS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx_i,
  input  logic          s_tick_i,
  input  logic [SW-1:0] s_i,
  output logic          rx_s_o,
  output logic          vote_now_o,
  output logic          vote_o
);

  localparam logic [SW-1:0] S_V0 = SW'(vote_pos(OVS, 0));
  localparam logic [SW-1:0] S_V1 = SW'(vote_pos(OVS, 1));
  localparam logic [SW-1:0] S_V2 = SW'(vote_pos(OVS, 2));

  logic [1:0] sync_q;
  logic [2:0] smp_q;
  logic       sample_en;

  assign sample_en = s_tick_i && ((s_i == S_V0) || (s_i == S_V1) || (s_i == S_V2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      smp_q  <= 3'b000;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      if (sample_en) smp_q <= {smp_q[1:0], sync_q[1]};
    end
  end

  assign rx_s_o     = sync_q[1];
  // Live vote folds in the third sample being taken on this very tick.
  assign vote_now_o = maj3(smp_q[1], smp_q[0], sync_q[1]);
  assign vote_o     = maj3(smp_q[2], smp_q[1], smp_q[0]);

endmodule

// File: rtl/uart_rx_ext.sv
// Oversampling UART receiver: configurable width/parity/stop bits, error and break
// flags, and a valid/ready holding register that reports overruns.
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int DBIT      = 8,
  parameter int OVS       = 16,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic            parity_err,
  output logic            frame_err,
  output logic            break_det,
  output logic            overrun
);

  localparam int SW = $clog2(OVS);
  localparam int NW = $clog2(DBIT);
  localparam int KW = $clog2(STOP_BITS + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVS - 1);
  localparam logic [SW-1:0] S_DEC  = SW'(vote_pos(OVS, 2));
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
  localparam logic [KW-1:0] K_LAST = KW'(STOP_BITS - 1);

  uart_state_e     state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [KW-1:0]   k_q, k_d;
  logic [DBIT-1:0] shreg_q, shreg_d;
  logic            par_bit_q, par_bit_d;
  logic            stop0_q, stop0_d;
  logic            frm_q, frm_d;
  logic            armed_q, armed_d;
  logic            done;
  logic            rx_s, vote_now, vote;
  logic            ones_odd, perr_now, brk_now, load;

  logic [DBIT-1:0] dout_q;
  logic            valid_q, perr_q, ferr_q, brk_q, ovr_q;

  uart_majority_sampler #(.OVS(OVS), .SW(SW)) u_sampler (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_i       (rx),
    .s_tick_i   (s_tick),
    .s_i        (s_q),
    .rx_s_o     (rx_s),
    .vote_now_o (vote_now),
    .vote_o     (vote)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      s_q       <= '0;
      n_q       <= '0;
      k_q       <= '0;
      shreg_q   <= '0;
      par_bit_q <= 1'b0;
      stop0_q   <= 1'b0;
      frm_q     <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      k_q       <= k_d;
      shreg_q   <= shreg_d;
      par_bit_q <= par_bit_d;
      stop0_q   <= stop0_d;
      frm_q     <= frm_d;
      armed_q   <= armed_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    n_d       = n_q;
    k_d       = k_q;
    shreg_d   = shreg_q;
    par_bit_d = par_bit_q;
    stop0_d   = stop0_q;
    frm_d     = frm_q;
    // A new start needs a high-to-low transition; a low line after a frame is ignored.
    armed_d   = armed_q | rx_s;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (armed_q && !rx_s) begin
          state_d = START;
          s_d     = '0;
          armed_d = 1'b0;
          frm_d   = 1'b0;
        end
      end
      START: begin
        if (s_tick) begin
          if ((s_q == S_DEC) && vote_now) begin
            state_d = IDLE;
            s_d     = '0;
          end else if (s_q == S_LAST) begin
            state_d = DATA;
            s_d     = '0;
            n_d     = '0;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            s_d     = '0;
            shreg_d = {vote, shreg_q[DBIT-1:1]};
            if (n_q == N_LAST) begin
              state_d = (PARITY != PAR_NONE) ? PAR : STOP;
              k_d     = '0;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      PAR: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            par_bit_d = vote;
            state_d   = STOP;
            s_d       = '0;
            k_d       = '0;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == S_DEC) begin
            if (!vote_now) frm_d = 1'b1;
            if (k_q == '0) stop0_d = vote_now;
            if (k_q == K_LAST) begin
              done    = 1'b1;
              state_d = IDLE;
              s_d     = '0;
              armed_d = vote_now;
            end else begin
              s_d = s_q + 1'b1;
            end
          end else if (s_q == S_LAST) begin
            s_d = '0;
            k_d = k_q + 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ones_odd = ^shreg_q;
  assign perr_now = (PARITY == PAR_NONE) ? 1'b0 :
                    (PARITY == PAR_ODD)  ? ~(ones_odd ^ par_bit_q) : (ones_odd ^ par_bit_q);
  assign brk_now  = (shreg_q == '0) && ((PARITY == PAR_NONE) || !par_bit_q) && !stop0_d;
  assign load     = done && (!valid_q || dout_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= done && !load;
      if (load) begin
        dout_q  <= shreg_q;
        perr_q  <= perr_now;
        ferr_q  <= frm_d;
        brk_q   <= brk_now;
        valid_q <= 1'b1;
      end else if (dout_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign break_det  = brk_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_ext.sv
// Bench for uart_rx_ext: an 8N1/OVS16 instance and an 8E2/OVS8 instance driven with
// directed and random frames, checked against a frame-level expectation queue.
module tb_uart_rx_ext;

  localparam int TDIV  = 3;
  localparam int BIT_A = 16 * TDIV;
  localparam int BIT_B = 8 * TDIV;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       bk;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rx_a, rx_b, ready_a, ready_b;
  int   tcnt = 0;
  logic s_tick;
  always @(posedge clk) tcnt <= (tcnt == TDIV - 1) ? 0 : tcnt + 1;
  assign s_tick = (tcnt == 0);

  logic [7:0] dout_a, dout_b;
  logic valid_a, perr_a, ferr_a, brk_a, ovr_a;
  logic valid_b, perr_b, ferr_b, brk_b, ovr_b;

  uart_rx_ext #(.DBIT(8), .OVS(16), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx(rx_a), .s_tick(s_tick), .dout(dout_a),
    .dout_valid(valid_a), .dout_ready(ready_a), .parity_err(perr_a),
    .frame_err(ferr_a), .break_det(brk_a), .overrun(ovr_a)
  );

  uart_rx_ext #(.DBIT(8), .OVS(8), .PARITY(1), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx(rx_b), .s_tick(s_tick), .dout(dout_b),
    .dout_valid(valid_b), .dout_ready(ready_b), .parity_err(perr_b),
    .frame_err(ferr_b), .break_det(brk_b), .overrun(ovr_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  exp_t qa[$];
  exp_t qb[$];
  logic held_a = 1'b0, held_b = 1'b0, ovr_prev_a = 1'b0;
  int   words_a = 0, words_b = 0, vcyc_a = 0, ovr_cyc_a = 0, ovr_pls_a = 0, ovr_cyc_b = 0;
  time  last_word_a = 0, t_start_a = 0;

  always @(posedge clk) begin
    held_a <= valid_a && !ready_a;
    held_b <= valid_b && !ready_b;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (valid_a) vcyc_a++;
      if (ovr_a) ovr_cyc_a++;
      if (ovr_a && !ovr_prev_a) ovr_pls_a++;
      if (ovr_b) ovr_cyc_b++;
      if (valid_a && !held_a) begin
        words_a++;
        last_word_a = $time;
        if (qa.size() == 0) check("a_unexpected_word", qa.size(), 1);
        else begin
          e = qa.pop_front();
          check("a_dout", dout_a, e.d);
          check("a_parity_err", perr_a, e.pe);
          check("a_frame_err", ferr_a, e.fe);
          check("a_break_det", brk_a, e.bk);
        end
      end
      if (valid_b && !held_b) begin
        words_b++;
        if (qb.size() == 0) check("b_unexpected_word", qb.size(), 1);
        else begin
          e = qb.pop_front();
          check("b_dout", dout_b, e.d);
          check("b_parity_err", perr_b, e.pe);
          check("b_frame_err", ferr_b, e.fe);
          check("b_break_det", brk_b, e.bk);
        end
      end
    end
    ovr_prev_a = ovr_a;
  end

  task automatic align();
    do @(negedge clk); while (tcnt != 1);
  endtask

  task automatic push_a(input logic [7:0] d, input logic stop);
    exp_t e;
    e.d  = d;
    e.pe = 1'b0;
    e.fe = !stop;
    e.bk = (d == 8'h00) && !stop;
    qa.push_back(e);
  endtask

  task automatic send_a(input logic [7:0] d, input logic stop);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    t_start_a = $time;
    for (int i = 0; i < 10; i++) begin
      rx_a = bits[i];
      repeat (BIT_A) @(negedge clk);
    end
    rx_a = 1'b1;
  endtask

  task automatic frame_a(input logic [7:0] d, input logic stop, input logic deliver);
    if (deliver) push_a(d, stop);
    align();
    send_a(d, stop);
    repeat (stop ? 4 : BIT_A) @(negedge clk);
  endtask

  task automatic frame_b(input logic [7:0] d, input logic p, input logic s1, input logic s2);
    exp_t e;
    logic [11:0] bits;
    e.d  = d;
    e.pe = p ^ (^d);
    e.fe = !(s1 && s2);
    e.bk = (d == 8'h00) && !p && !s1;
    qb.push_back(e);
    bits = {s2, s1, p, d, 1'b0};
    align();
    for (int i = 0; i < 12; i++) begin
      rx_b = bits[i];
      repeat (BIT_B) @(negedge clk);
    end
    rx_b = 1'b1;
    repeat (s2 ? 4 : BIT_B) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, w0, o0, oc0, v0, r;
    logic [7:0] d;
    logic p, s1, s2;

    rst_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_dout", dout_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_flags", {perr_a, ferr_a, brk_a, ovr_a}, 0);
    check("rst_b_valid", valid_b, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1 basic word with 1-cycle valid
    w0 = words_a; v0 = vcyc_a;
    frame_a(8'hA5, 1'b1, 1'b1);
    check("t1_words", words_a, w0 + 1);
    check("t1_valid_cycles", vcyc_a - v0, 1);
    lat = int'((last_word_a - t_start_a) / 10);
    check("t1_latency_sane", lat > 4 * BIT_A, 1);

    // even parity, wrong then right parity bit
    frame_b(8'h07, 1'b0, 1'b1, 1'b1);
    frame_b(8'h07, 1'b1, 1'b1, 1'b1);
    check("t2_words_b", words_b, 2);

    // 4-tick glitch is rejected, next frame clean
    w0 = words_a;
    align();
    rx_a = 1'b0;
    repeat (4 * TDIV) @(negedge clk);
    rx_a = 1'b1;
    repeat (2 * BIT_A) @(negedge clk);
    check("t3_glitch_no_word", words_a, w0);
    frame_a(8'h3C, 1'b1, 1'b1);
    check("t3_words", words_a, w0 + 1);

    // break and plain framing error
    frame_a(8'h00, 1'b0, 1'b1);
    frame_a(8'h55, 1'b0, 1'b1);

    // overrun while holding, then reload in the acceptance cycle
    ready_a = 1'b0;
    o0 = ovr_pls_a; oc0 = ovr_cyc_a;
    frame_a(8'h11, 1'b1, 1'b1);
    check("t5_hold_dout", dout_a, 8'h11);
    frame_a(8'h22, 1'b1, 1'b0);
    check("t5_overrun_pulses", ovr_pls_a - o0, 1);
    check("t5_overrun_cycles", ovr_cyc_a - oc0, 1);
    check("t5_kept_dout", dout_a, 8'h11);
    check("t5_kept_valid", valid_a, 1);
    push_a(8'h22, 1'b1);
    align();
    fork
      send_a(8'h22, 1'b1);
      begin
        repeat (lat - 1) @(negedge clk);
        ready_a = 1'b1;
        @(negedge clk);
        ready_a = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    check("t5_accept_no_overrun", ovr_pls_a - o0, 1);
    check("t5_accept_dout", dout_a, 8'h22);
    check("t5_accept_valid", valid_a, 1);
    ready_a = 1'b1;
    repeat (2) @(negedge clk);
    check("t5_drained", valid_a, 0);

    // reset in the middle of a frame
    w0 = words_a;
    align();
    fork
      send_a(8'hF0, 1'b1);
      begin
        repeat (BIT_A * 3 + BIT_A / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_rst_dout", dout_a, 0);
        check("t6_rst_valid", valid_a, 0);
        check("t6_rst_flags", {perr_a, ferr_a, brk_a, ovr_a}, 0);
        repeat (2 * BIT_A) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    repeat (4) @(negedge clk);
    check("t6_no_partial", words_a, w0);
    frame_a(8'h81, 1'b1, 1'b1);
    check("t6_words", words_a, w0 + 1);

    // random traffic on A: glitches, bad stops, breaks, varied gaps
    o0 = ovr_pls_a;
    for (int i = 0; i < 20; i++) begin
      r = int'($urandom_range(0, 99));
      d = 8'($urandom);
      if (r < 8) d = 8'h00;
      if ($urandom_range(0, 3) == 0) begin
        rx_a = 1'b0;
        repeat ($urandom_range(1, 5) * TDIV) @(negedge clk);
        rx_a = 1'b1;
        repeat (BIT_A) @(negedge clk);
      end
      frame_a(d, r >= 15, 1'b1);
      repeat ($urandom_range(0, BIT_A / 2)) @(negedge clk);
    end
    check("rand_a_no_overrun", ovr_pls_a - o0, 0);

    // random traffic on B: parity and both stop bits randomised
    for (int i = 0; i < 12; i++) begin
      d  = 8'($urandom);
      if ($urandom_range(0, 5) == 0) d = 8'h00;
      p  = ((^d) ^ ($urandom_range(0, 3) == 0));
      s1 = ($urandom_range(0, 4) != 0);
      s2 = ($urandom_range(0, 4) != 0);
      frame_b(d, p, s1, s2);
      repeat ($urandom_range(0, BIT_B / 2)) @(negedge clk);
    end

    repeat (2 * BIT_A) @(negedge clk);
    check("end_queue_a_empty", qa.size(), 0);
    check("end_queue_b_empty", qb.size(), 0);
    check("end_overrun_b", ovr_cyc_b, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
